// File: rtl/dct_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dct_ctrl_pkg
// Shared constants for the DCT control register block: register byte
// offsets, bit positions inside CTRL/STATUS, the VERSION value, AXI4-Lite
// response codes, the register-select enum and a byte-strobe merge helper.
// ---------------------------------------------------------------------------
package dct_ctrl_pkg;

  // Register byte offsets (word aligned)
  localparam int unsigned OFF_CTRL    = 32'h000;
  localparam int unsigned OFF_STATUS  = 32'h004;
  localparam int unsigned OFF_SRC     = 32'h008;
  localparam int unsigned OFF_DST     = 32'h00C;
  localparam int unsigned OFF_LEN     = 32'h010;
  localparam int unsigned OFF_VERSION = 32'h014;

  // CTRL bits
  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  // STATUS bits
  localparam int STAT_BUSY_BIT      = 0;
  localparam int STAT_DONE_BIT      = 1;
  localparam int STAT_START_ERR_BIT = 2;

  localparam logic [31:0] VERSION = 32'h0001_0000;

  // AXI4-Lite response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_STATUS,
    REG_SRC,
    REG_DST,
    REG_LEN,
    REG_VERSION,
    REG_NONE
  } reg_sel_e;

  // Replace only the bytes whose strobe is set.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dct_ctrl_if.sv
// ---------------------------------------------------------------------------
// dct_ctrl_if
// AXI4-Lite slave bus bundle (AW, W, B, AR, R channels).
// master modport: the bus initiator; slave modport: the register block.
// ---------------------------------------------------------------------------
interface dct_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, input  awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/dct_ctrl_axil_if.sv
// ---------------------------------------------------------------------------
// dct_ctrl_axil_if
// AXI4-Lite slave handshake engine. Latches AW and W independently, then
// issues a one-cycle write-commit strobe (wr_en_o/addr/data/strb) and raises
// bvalid on the same edge the register file updates. Reads present the AR
// address as a request (rd_en_o/rd_addr_o) and register the response.
// Ports:
//   aclk, areset     clock, synchronous active-high reset
//   axi              AXI4-Lite slave modport
//   wr_*_o, wr_err_i write commit strobe / decode error from register file
//   rd_*_o, rd_*_i   read request / combinational response from register file
// ---------------------------------------------------------------------------
module dct_ctrl_axil_if
  import dct_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                aclk,
  input  logic                areset,
  dct_ctrl_if.slave           axi,
  output logic                wr_en_o,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic [DATA_W-1:0]   wr_data_o,
  output logic [DATA_W/8-1:0] wr_strb_o,
  input  logic                wr_err_i,
  output logic                rd_en_o,
  output logic [ADDR_W-1:0]   rd_addr_o,
  input  logic [DATA_W-1:0]   rd_data_i,
  input  logic                rd_err_i
);

  logic                live_q;     // low during reset and its first cycle
  logic                aw_lat_q;
  logic [ADDR_W-1:0]   awaddr_q;
  logic                w_lat_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                bvalid_q;
  logic [1:0]          bresp_q;
  logic                rvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          rresp_q;

  logic aw_hs, w_hs, ar_hs;

  assign axi.awready = live_q & ~aw_lat_q & ~bvalid_q;
  assign axi.wready  = live_q & ~w_lat_q  & ~bvalid_q;
  assign axi.arready = live_q & ~rvalid_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;

  assign aw_hs = axi.awvalid & axi.awready;
  assign w_hs  = axi.wvalid  & axi.wready;
  assign ar_hs = axi.arvalid & axi.arready;

  // Both halves latched: commit on the next edge. Latches clear on that edge,
  // so the strobe is high for exactly one cycle.
  assign wr_en_o   = aw_lat_q & w_lat_q;
  assign wr_addr_o = awaddr_q;
  assign wr_data_o = wdata_q;
  assign wr_strb_o = wstrb_q;

  assign rd_en_o   = ar_hs;
  assign rd_addr_o = axi.araddr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge aclk) begin
    if (areset) begin
      // NOTE: data/address holding registers are reset too, so every output
      // of the block is a known 0 after reset and in-flight beats are lost.
      live_q   <= 1'b0;
      aw_lat_q <= 1'b0;
      awaddr_q <= '0;
      w_lat_q  <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      live_q <= 1'b1;

      if (aw_hs) begin
        aw_lat_q <= 1'b1;
        awaddr_q <= axi.awaddr;
      end
      if (w_hs) begin
        w_lat_q <= 1'b1;
        wdata_q <= axi.wdata;
        wstrb_q <= axi.wstrb;
      end

      if (wr_en_o) begin
        aw_lat_q <= 1'b0;
        w_lat_q  <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err_i ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && axi.bready) begin
        bvalid_q <= 1'b0;
      end

      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data_i;
        rresp_q  <= rd_err_i ? RESP_SLVERR : RESP_OKAY;
      end else if (rvalid_q && axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dct_ctrl_regs.sv
// ---------------------------------------------------------------------------
// dct_ctrl_regs
// AXI4-Lite control/status register file for a 4x4 DCT core.
//   0x000 CTRL     bit0 START (W1, reads 0), bit1 IRQ_EN
//   0x004 STATUS   bit0 BUSY (RO), bit1 DONE (W1C), bit2 START_ERR (W1C)
//   0x008 SRC_ADDR, 0x00C DST_ADDR, 0x010 LEN[15:0], 0x014 VERSION (RO)
// Ports:
//   aclk, areset         clock, synchronous active-high reset
//   s_axi_*              AXI4-Lite slave (only DATA_W = 32 is supported)
//   core_busy/core_done  core status level / completion pulse
//   start_pulse          one-cycle core start
//   src_addr/dst_addr/blk_count  DMA setup straight from the registers
//   irq                  registered IRQ_EN & DONE
// ---------------------------------------------------------------------------
module dct_ctrl_regs
  import dct_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  input  logic                core_busy,
  input  logic                core_done,
  output logic                start_pulse,
  output logic [31:0]         src_addr,
  output logic [31:0]         dst_addr,
  output logic [15:0]         blk_count,
  output logic                irq
);

  dct_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  assign axi.awaddr    = s_axi_awaddr;
  assign axi.awvalid   = s_axi_awvalid;
  assign s_axi_awready = axi.awready;
  assign axi.wdata     = s_axi_wdata;
  assign axi.wstrb     = s_axi_wstrb;
  assign axi.wvalid    = s_axi_wvalid;
  assign s_axi_wready  = axi.wready;
  assign s_axi_bresp   = axi.bresp;
  assign s_axi_bvalid  = axi.bvalid;
  assign axi.bready    = s_axi_bready;
  assign axi.araddr    = s_axi_araddr;
  assign axi.arvalid   = s_axi_arvalid;
  assign s_axi_arready = axi.arready;
  assign s_axi_rdata   = axi.rdata;
  assign s_axi_rresp   = axi.rresp;
  assign s_axi_rvalid  = axi.rvalid;
  assign axi.rready    = s_axi_rready;

  logic                wr_en, wr_err, rd_en, rd_err;
  logic [ADDR_W-1:0]   wr_addr, rd_addr;
  logic [DATA_W-1:0]   wr_data, rd_data;
  logic [DATA_W/8-1:0] wr_strb;

  dct_ctrl_axil_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_axil (
    .aclk      (aclk),
    .areset    (areset),
    .axi       (axi),
    .wr_en_o   (wr_en),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data),
    .wr_strb_o (wr_strb),
    .wr_err_i  (wr_err),
    .rd_en_o   (rd_en),
    .rd_addr_o (rd_addr),
    .rd_data_i (rd_data),
    .rd_err_i  (rd_err)
  );

  // Byte-lane address bits are ignored by the map.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{wr_addr[1:0], rd_addr[1:0]};

  function automatic reg_sel_e decode(input logic [ADDR_W-3:0] word);
    case (word)
      (ADDR_W-2)'(OFF_CTRL    >> 2): return REG_CTRL;
      (ADDR_W-2)'(OFF_STATUS  >> 2): return REG_STATUS;
      (ADDR_W-2)'(OFF_SRC     >> 2): return REG_SRC;
      (ADDR_W-2)'(OFF_DST     >> 2): return REG_DST;
      (ADDR_W-2)'(OFF_LEN     >> 2): return REG_LEN;
      (ADDR_W-2)'(OFF_VERSION >> 2): return REG_VERSION;
      default:                       return REG_NONE;
    endcase
  endfunction

  reg_sel_e wr_sel, rd_sel;
  assign wr_sel = decode(wr_addr[ADDR_W-1:2]);
  assign rd_sel = decode(rd_addr[ADDR_W-1:2]);
  assign wr_err = (wr_sel == REG_NONE);

  logic        irq_en_q, irq_en_d;
  logic        done_q, done_d;
  logic        start_err_q, start_err_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [15:0] len_q, len_d;
  logic        start_pulse_q, start_d;
  logic        irq_q;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    irq_en_d    = irq_en_q;
    done_d      = done_q;
    start_err_d = start_err_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    start_d     = 1'b0;

    if (wr_en) begin
      case (wr_sel)
        REG_CTRL: if (wr_strb[0]) begin
          irq_en_d = wr_data[CTRL_IRQ_EN_BIT];
          if (wr_data[CTRL_START_BIT]) begin
            if (core_busy) start_err_d = 1'b1;
            else           start_d     = 1'b1;
          end
        end
        REG_STATUS: if (wr_strb[0]) begin
          if (wr_data[STAT_DONE_BIT])      done_d      = 1'b0;
          if (wr_data[STAT_START_ERR_BIT]) start_err_d = 1'b0;
        end
        REG_SRC: src_d = apply_wstrb(src_q, wr_data, wr_strb);
        REG_DST: dst_d = apply_wstrb(dst_q, wr_data, wr_strb);
        REG_LEN: begin
          if (wr_strb[0]) len_d[7:0]  = wr_data[7:0];
          if (wr_strb[1]) len_d[15:8] = wr_data[15:8];
        end
        default: ; // VERSION is read-only; unmapped writes change nothing
      endcase
    end

    // Evaluated after the W1C so a coincident completion is never lost.
    if (core_done) done_d = 1'b1;
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (rd_en) begin
      case (rd_sel)
        REG_CTRL:    rd_data[CTRL_IRQ_EN_BIT] = irq_en_q;
        REG_STATUS: begin
          rd_data[STAT_BUSY_BIT]      = core_busy;
          rd_data[STAT_DONE_BIT]      = done_q;
          rd_data[STAT_START_ERR_BIT] = start_err_q;
        end
        REG_SRC:     rd_data        = src_q;
        REG_DST:     rd_data        = dst_q;
        REG_LEN:     rd_data[15:0]  = len_q;
        REG_VERSION: rd_data        = VERSION;
        default:     rd_err         = 1'b1;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      irq_en_q      <= 1'b0;
      done_q        <= 1'b0;
      start_err_q   <= 1'b0;
      src_q         <= '0;
      dst_q         <= '0;
      len_q         <= '0;
      start_pulse_q <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      irq_en_q      <= irq_en_d;
      done_q        <= done_d;
      start_err_q   <= start_err_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      len_q         <= len_d;
      start_pulse_q <= start_d;
      irq_q         <= irq_en_q & done_q;
    end
  end

  assign start_pulse = start_pulse_q;
  assign irq         = irq_q;
  assign src_addr    = src_q;
  assign dst_addr    = dst_q;
  assign blk_count   = len_q;

endmodule

// File: tb/tb_dct_ctrl_regs.sv
// ---------------------------------------------------------------------------
// tb_dct_ctrl_regs
// Directed self-checking bench for dct_ctrl_regs. Inputs change and outputs
// are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_dct_ctrl_regs;
  import dct_ctrl_pkg::*;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        core_busy = 1'b0;
  logic        core_done = 1'b0;
  logic        start_pulse, irq;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] blk_count;

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;
  int cnt0;

  dct_ctrl_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  dct_ctrl_regs #(.ADDR_W(12), .DATA_W(32)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axi_awaddr  (bus.awaddr),
    .s_axi_awvalid (bus.awvalid),
    .s_axi_awready (bus.awready),
    .s_axi_wdata   (bus.wdata),
    .s_axi_wstrb   (bus.wstrb),
    .s_axi_wvalid  (bus.wvalid),
    .s_axi_wready  (bus.wready),
    .s_axi_bresp   (bus.bresp),
    .s_axi_bvalid  (bus.bvalid),
    .s_axi_bready  (bus.bready),
    .s_axi_araddr  (bus.araddr),
    .s_axi_arvalid (bus.arvalid),
    .s_axi_arready (bus.arready),
    .s_axi_rdata   (bus.rdata),
    .s_axi_rresp   (bus.rresp),
    .s_axi_rvalid  (bus.rvalid),
    .s_axi_rready  (bus.rready),
    .core_busy     (core_busy),
    .core_done     (core_done),
    .start_pulse   (start_pulse),
    .src_addr      (src_addr),
    .dst_addr      (dst_addr),
    .blk_count     (blk_count),
    .irq           (irq)
  );

  always #5 aclk = ~aclk;

  // Counts cycles with start_pulse high.
  always @(negedge aclk) if (start_pulse) pulse_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_aw(input logic [11:0] a);
    int n = 0;
    bus.awaddr  = a;
    bus.awvalid = 1'b1;
    while (!bus.awready && n < 20) begin @(negedge aclk); n++; end
    if (!bus.awready) check("aw_timeout", {31'b0, bus.awready}, 32'd1);
    @(negedge aclk);
    bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    bus.wdata  = d;
    bus.wstrb  = s;
    bus.wvalid = 1'b1;
    while (!bus.wready && n < 20) begin @(negedge aclk); n++; end
    if (!bus.wready) check("w_timeout", {31'b0, bus.wready}, 32'd1);
    @(negedge aclk);
    bus.wvalid = 1'b0;
  endtask

  task automatic wait_b(input string tag, input logic [1:0] exp_resp, input int hold);
    int n = 0;
    while (!bus.bvalid && n < 20) begin @(negedge aclk); n++; end
    if (!bus.bvalid) check({tag, "_b_timeout"}, {31'b0, bus.bvalid}, 32'd1);
    check({tag, "_bresp"}, {30'b0, bus.bresp}, {30'b0, exp_resp});
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      check({tag, "_bvalid_hold"}, {31'b0, bus.bvalid}, 32'd1);
      check({tag, "_bresp_hold"}, {30'b0, bus.bresp}, {30'b0, exp_resp});
    end
    bus.bready = 1'b1;
    @(negedge aclk);
    bus.bready = 1'b0;
  endtask

  task automatic axi_write(input string tag, input logic [11:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] exp_resp, input int hold);
    send_aw(a);
    send_w(d, s);
    wait_b(tag, exp_resp, hold);
  endtask

  task automatic axi_read(input string tag, input logic [11:0] a, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input int hold);
    int n = 0;
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    while (!bus.arready && n < 20) begin @(negedge aclk); n++; end
    if (!bus.arready) check({tag, "_ar_timeout"}, {31'b0, bus.arready}, 32'd1);
    @(negedge aclk);
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 20) begin @(negedge aclk); n++; end
    if (!bus.rvalid) check({tag, "_r_timeout"}, {31'b0, bus.rvalid}, 32'd1);
    check({tag, "_rdata"}, bus.rdata, exp_data);
    check({tag, "_rresp"}, {30'b0, bus.rresp}, {30'b0, exp_resp});
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      check({tag, "_rvalid_hold"}, {31'b0, bus.rvalid}, 32'd1);
      check({tag, "_rdata_hold"}, bus.rdata, exp_data);
    end
    bus.rready = 1'b1;
    @(negedge aclk);
    bus.rready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.awaddr = '0; bus.awvalid = 1'b0;
    bus.wdata  = '0; bus.wstrb   = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    // Reset state
    repeat (3) @(negedge aclk);
    check("rst_awready", {31'b0, bus.awready}, 32'd0);
    check("rst_wready",  {31'b0, bus.wready},  32'd0);
    check("rst_arready", {31'b0, bus.arready}, 32'd0);
    check("rst_bvalid",  {31'b0, bus.bvalid},  32'd0);
    check("rst_rvalid",  {31'b0, bus.rvalid},  32'd0);
    check("rst_src",     src_addr, 32'd0);
    check("rst_irq",     {31'b0, irq}, 32'd0);
    areset = 1'b0;
    @(negedge aclk);
    check("post_rst_awready", {31'b0, bus.awready}, 32'd1);
    check("post_rst_arready", {31'b0, bus.arready}, 32'd1);

    // W two cycles ahead of AW
    send_w(32'h1000_0000, 4'hF);
    check("w_first_wready",  {31'b0, bus.wready},  32'd0);
    check("w_first_awready", {31'b0, bus.awready}, 32'd1);
    repeat (2) @(negedge aclk);
    send_aw(12'h008);
    wait_b("src", RESP_OKAY, 0);
    check("src_addr", src_addr, 32'h1000_0000);
    axi_read("src_rd", 12'h008, 32'h1000_0000, RESP_OKAY, 0);

    // Byte strobes
    axi_write("dst0", 12'h00C, 32'h0000_0000, 4'hF, RESP_OKAY, 0);
    axi_write("dst1", 12'h00C, 32'hAABB_CCDD, 4'b0101, RESP_OKAY, 0);
    check("dst_addr_strb", dst_addr, 32'h00BB_00DD);
    axi_read("dst_rd", 12'h00C, 32'h00BB_00DD, RESP_OKAY, 0);
    axi_write("len", 12'h010, 32'hFFFF_1234, 4'hF, RESP_OKAY, 0);
    check("blk_count", {16'b0, blk_count}, 32'h0000_1234);
    axi_read("len_rd", 12'h010, 32'h0000_1234, RESP_OKAY, 0);

    // START while idle: one pulse coincident with bvalid
    cnt0 = pulse_cnt;
    send_aw(12'h000);
    send_w(32'h0000_0003, 4'hF);
    for (int n = 0; n < 20 && !bus.bvalid; n++) @(negedge aclk);
    check("start_with_bvalid", {31'b0, start_pulse}, 32'd1);
    bus.bready = 1'b1;
    @(negedge aclk);
    bus.bready = 1'b0;
    check("start_one_cycle", {31'b0, start_pulse}, 32'd0);
    @(negedge aclk);
    check("start_count_idle", pulse_cnt - cnt0, 32'd1);
    axi_read("ctrl_rd", 12'h000, 32'h0000_0002, RESP_OKAY, 0);

    // START while busy: no pulse, START_ERR set
    core_busy = 1'b1;
    cnt0 = pulse_cnt;
    axi_write("start_busy", 12'h000, 32'h0000_0003, 4'hF, RESP_OKAY, 0);
    @(negedge aclk);
    check("start_count_busy", pulse_cnt - cnt0, 32'd0);
    axi_read("status_err", 12'h004, 32'h0000_0005, RESP_OKAY, 0);
    axi_write("clr_err", 12'h004, 32'h0000_0004, 4'hF, RESP_OKAY, 0);
    axi_read("status_busy", 12'h004, 32'h0000_0001, RESP_OKAY, 0);
    core_busy = 1'b0;

    // START with byte-0 strobe off: ignored, IRQ_EN unchanged
    cnt0 = pulse_cnt;
    axi_write("start_nostrb", 12'h000, 32'h0000_0001, 4'b1110, RESP_OKAY, 0);
    @(negedge aclk);
    check("start_count_nostrb", pulse_cnt - cnt0, 32'd0);
    axi_read("ctrl_nostrb", 12'h000, 32'h0000_0002, RESP_OKAY, 0);

    // core_done -> DONE, irq one cycle later
    core_done = 1'b1;
    @(negedge aclk);
    core_done = 1'b0;
    check("irq_lag", {31'b0, irq}, 32'd0);
    @(negedge aclk);
    check("irq_high", {31'b0, irq}, 32'd1);
    axi_read("status_done", 12'h004, 32'h0000_0002, RESP_OKAY, 0);
    axi_write("w1c_nostrb", 12'h004, 32'h0000_0002, 4'h0, RESP_OKAY, 0);
    axi_read("status_keep", 12'h004, 32'h0000_0002, RESP_OKAY, 0);
    axi_write("w1c_done", 12'h004, 32'h0000_0002, 4'hF, RESP_OKAY, 0);
    check("irq_cleared", {31'b0, irq}, 32'd0);
    axi_read("status_clr", 12'h004, 32'h0000_0000, RESP_OKAY, 0);

    // core_done coincident with the DONE W1C commit: set wins
    send_aw(12'h004);
    send_w(32'h0000_0002, 4'hF);
    core_done = 1'b1;
    @(negedge aclk);
    core_done = 1'b0;
    wait_b("w1c_race", RESP_OKAY, 0);
    axi_read("status_race", 12'h004, 32'h0000_0002, RESP_OKAY, 0);
    check("irq_race", {31'b0, irq}, 32'd1);
    axi_write("w1c_done2", 12'h004, 32'h0000_0002, 4'hF, RESP_OKAY, 0);

    // Read and write committing on the same edge: read sees old value
    send_aw(12'h008);
    send_w(32'h2222_2222, 4'hF);
    bus.araddr  = 12'h008;
    bus.arvalid = 1'b1;
    @(negedge aclk);
    bus.arvalid = 1'b0;
    check("rw_same_rvalid", {31'b0, bus.rvalid}, 32'd1);
    check("rw_same_rdata", bus.rdata, 32'h1000_0000);
    bus.rready = 1'b1;
    @(negedge aclk);
    bus.rready = 1'b0;
    wait_b("rw_same", RESP_OKAY, 0);
    check("rw_same_src", src_addr, 32'h2222_2222);
    axi_read("rw_same_rd", 12'h008, 32'h2222_2222, RESP_OKAY, 0);

    // VERSION, unmapped accesses, back-pressure
    axi_read("version", 12'h014, 32'h0001_0000, RESP_OKAY, 5);
    axi_read("unmapped_rd", 12'h020, 32'h0000_0000, RESP_SLVERR, 0);
    axi_write("unmapped_wr", 12'h020, 32'hFFFF_FFFF, 4'hF, RESP_SLVERR, 5);
    check("unmapped_src", src_addr, 32'h2222_2222);
    check("unmapped_dst", dst_addr, 32'h00BB_00DD);
    check("unmapped_len", {16'b0, blk_count}, 32'h0000_1234);
    axi_read("unmapped_ctrl", 12'h000, 32'h0000_0002, RESP_OKAY, 0);
    axi_read("lsb_ignored", 12'h00E, 32'h00BB_00DD, RESP_OKAY, 0);

    // Reset with AW latched and W pending
    send_aw(12'h00C);
    check("aw_latched_awready", {31'b0, bus.awready}, 32'd0);
    check("aw_latched_wready",  {31'b0, bus.wready},  32'd1);
    areset = 1'b1;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("rst_flight_bvalid", {31'b0, bus.bvalid}, 32'd0);
    end
    check("rst2_src", src_addr, 32'd0);
    check("rst2_dst", dst_addr, 32'd0);
    check("rst2_len", {16'b0, blk_count}, 32'd0);
    check("rst2_irq", {31'b0, irq}, 32'd0);
    axi_read("rst2_ctrl",   12'h000, 32'h0000_0000, RESP_OKAY, 0);
    axi_read("rst2_status", 12'h004, 32'h0000_0000, RESP_OKAY, 0);
    axi_read("rst2_srcrd",  12'h008, 32'h0000_0000, RESP_OKAY, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dct_ctrl_regs.md
DCT_CTRL_REGS -- requirements
Module: dct_ctrl_regs

Interface
REQ-001 The block SHALL have one clock, aclk; reset is areset, synchronous and active-high.
REQ-002 Parameters SHALL be: ADDR_W, default 12, AXI4-Lite address width; DATA_W, default 32, data width (only 32 supported).
REQ-003 Ports SHALL be, in this order:
- aclk  in  1  clock
- areset  in  1  sync active-high reset
- s_axi_awaddr  in  12  write address
- s_axi_awvalid/awready  in/out  1  AW handshake
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte strobes
- s_axi_wvalid/wready  in/out  1  W handshake
- s_axi_bresp  out  2  write response
- s_axi_bvalid/bready  out/in  1  B handshake
- s_axi_araddr  in  12  read address
- s_axi_arvalid/arready  in/out  1  AR handshake
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid/rready  out/in  1  R handshake
- core_busy  in  1  DCT core busy level
- core_done  in  1  one-cycle completion pulse
- start_pulse  out  1  one-cycle core start
- src_addr, dst_addr  out  32  DMA addresses
- blk_count  out  16  number of 4x4 blocks
- irq  out  1  level interrupt

Function
REQ-004 Register map (word-aligned, awaddr[1:0] ignored): 0x000 CTRL (bit0 START W1 self-clearing, reads 0; bit1 IRQ_EN RW); 0x004 STATUS (bit0 BUSY RO = core_busy; bit1 DONE W1C; bit2 START_ERR W1C); 0x008 SRC_ADDR RW; 0x00C DST_ADDR RW; 0x010 LEN RW bits[15:0], [31:16] read 0; 0x014 VERSION RO 0x0001_0000.
REQ-005 RW registers SHALL honour wstrb per byte; W1C/W1 bits act only if their byte strobe is set.
REQ-006 AW and W SHALL be accepted independently in either order; awready and wready are high while the respective channel is unlatched and bvalid is low.
REQ-007 In the cycle after both AW and W are latched, the register update and bvalid rise SHALL occur together; bvalid holds until bready; no new AW/W is accepted until the B handshake completes.
REQ-008 bresp SHALL be OKAY (2'b00) for mapped addresses and SLVERR (2'b10) for unmapped ones; unmapped writes change nothing.
REQ-009 arready SHALL be high when rvalid is low; rvalid rises the cycle after an AR handshake with registered rdata/rresp, holds until rready; unmapped reads return 0 with SLVERR.
REQ-010 A read and a write committing in the same cycle SHALL be independent; the read returns the pre-write value.
REQ-011 Writing START=1 with core_busy=0 SHALL assert start_pulse for exactly one cycle, coincident with the bvalid rise; with core_busy=1 no pulse is issued and START_ERR is set.
REQ-012 core_done SHALL set DONE; if core_done and a DONE W1C coincide, set wins.
REQ-013 irq SHALL equal IRQ_EN AND DONE, registered (one cycle after either changes).
REQ-014 src_addr, dst_addr, blk_count SHALL reflect SRC_ADDR, DST_ADDR, LEN[15:0] directly.

Reset
REQ-015 On areset all registers, latches and outputs SHALL be 0 (awready/wready/arready rise the cycle after reset deasserts); a transaction in flight is discarded with no B/R response.

Structure
REQ-016 A package dct_ctrl_pkg SHALL hold register offsets, bit positions, VERSION constant and response codes (RESP_OKAY, RESP_SLVERR).
REQ-017 The AXI4-Lite handshake logic SHALL be a sub-module dct_ctrl_axil_if exposing a one-cycle write-commit strobe (addr, data, strb) and a read request/response port to the register decode in dct_ctrl_regs.

Verification
REQ-018 Write 0x1000_0000 to 0x008 with W issued two cycles before AW -> bresp OKAY, src_addr = 0x1000_0000, readback matches.
REQ-019 Write 0x0000_0003 to 0x000 with core_busy=0 -> start_pulse high exactly one cycle, IRQ_EN=1; repeat with core_busy=1 -> no pulse, STATUS reads 0x5.
REQ-020 Pulse core_done with IRQ_EN=1 -> STATUS bit1=1, irq high next cycle; write 0x2 to 0x004 -> irq low; coincident core_done and W1C -> DONE stays 1.
REQ-021 Write 0xAABB_CCDD to 0x00C with wstrb=4'b0101 over 0 -> dst_addr = 0x00BB_00DD.
REQ-022 Read 0x014 -> 0x0001_0000 OKAY; read/write 0x020 -> 0 / SLVERR, no state change; hold rready/bready low 5 cycles -> rvalid/bvalid and data stable.
REQ-023 Assert areset during an AW-latched, W-pending write -> no bvalid, all registers 0 afterwards.
